inst_sram_ctrl: RTL and testbench

INST_SRAM_CTRL -- requirements
Module: inst_sram_ctrl

---
 rtl/inst_sram_ctrl.sv | 158 +++++++++++++++
 tb/tb_inst_sram_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sram_ctrl.sv
// Single-port async SRAM controller shared by CPU instruction and data ports.
// Define SRAM_WAIT_STATE_EN to add one RD_WAIT cycle to every read.
module inst_sram_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INST_CE,
  input  logic        INST_WE,
  input  logic [3:0]  INST_BE,
  input  logic [31:0] INST_WDATA,
  input  logic [31:0] INST_VADDR,
  output logic [31:0] INST_RDATA,
  input  logic        DATA_CE,
  input  logic        DATA_WE,
  input  logic [3:0]  DATA_BE,
  input  logic [31:0] DATA_WDATA,
  input  logic [31:0] DATA_VADDR,
  output logic [31:0] DATA_RDATA,
  output logic        STALL_REQ,
  output logic [19:0] RAM_ADDR,
  output logic [3:0]  RAM_BE_N,
  output logic        RAM_CE_N,
  output logic        RAM_OE_N,
  output logic        RAM_WE_N,
  output logic [31:0] RAM_DQ_O,
  output logic        RAM_DQ_OE,
  input  logic [31:0] RAM_DQ_I
);

`ifdef SRAM_WAIT_STATE_EN
  typedef enum logic [2:0] {
    IDLE, RD, RD_WAIT, WR_SETUP, WR_PULSE, WR_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, RD, WR_SETUP, WR_PULSE, WR_DONE
  } state_t;
`endif

  state_t state, state_nx;

  logic        src_q;
  logic [19:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] inst_rdata_q;
  logic [31:0] data_rdata_q;

  logic [31:0] inst_phys;
  logic [31:0] data_phys;
  logic        rd_last;
  logic        leave_idle;
  logic        unused;

  assign inst_phys = {3'b000, INST_VADDR[28:0]};
  assign data_phys = {3'b000, DATA_VADDR[28:0]};

  // Instruction port is read-only; its write side is intentionally dropped.
  assign unused = ^{INST_WE, INST_BE, INST_WDATA,
                    inst_phys[31:22], inst_phys[1:0],
                    data_phys[31:22], data_phys[1:0]};

`ifdef SRAM_WAIT_STATE_EN
  assign rd_last = (state == RD_WAIT);
`else
  assign rd_last = (state == RD);
`endif

  assign leave_idle = (state == IDLE) && (state_nx != IDLE);

  always_comb begin
    state_nx  = state;
    RAM_CE_N  = 1'b1;
    RAM_OE_N  = 1'b1;
    RAM_WE_N  = 1'b1;
    RAM_BE_N  = 4'hF;
    RAM_DQ_OE = 1'b0;
    case (state)
      IDLE: begin
        if (DATA_CE && DATA_WE)
          state_nx = WR_SETUP;
        else if (DATA_CE || INST_CE)
          state_nx = RD;
      end
      RD: begin
        RAM_CE_N = 1'b0;
        RAM_OE_N = 1'b0;
        RAM_BE_N = 4'h0;
`ifdef SRAM_WAIT_STATE_EN
        state_nx = RD_WAIT;
`else
        state_nx = IDLE;
`endif
      end
`ifdef SRAM_WAIT_STATE_EN
      RD_WAIT: begin
        RAM_CE_N = 1'b0;
        RAM_OE_N = 1'b0;
        RAM_BE_N = 4'h0;
        state_nx = IDLE;
      end
`endif
      WR_SETUP: begin
        RAM_CE_N  = 1'b0;
        RAM_DQ_OE = 1'b1;
        RAM_BE_N  = ~be_q;
        state_nx  = WR_PULSE;
      end
      WR_PULSE: begin
        RAM_CE_N  = 1'b0;
        RAM_DQ_OE = 1'b1;
        RAM_BE_N  = ~be_q;
        RAM_WE_N  = 1'b0;
        state_nx  = WR_DONE;
      end
      WR_DONE: begin
        RAM_CE_N  = 1'b0;
        RAM_DQ_OE = 1'b1;
        RAM_BE_N  = ~be_q;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      src_q        <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (leave_idle) begin
        src_q   <= DATA_CE;
        addr_q  <= DATA_CE ? data_phys[21:2]
                           : inst_phys[21:2];
        be_q    <= DATA_BE;
        wdata_q <= DATA_WDATA;
      end
      if (rd_last) begin
        if (src_q)
          data_rdata_q <= RAM_DQ_I;
        else
          inst_rdata_q <= RAM_DQ_I;
      end
    end
  end

  assign RAM_ADDR   = addr_q;
  assign RAM_DQ_O   = wdata_q;
  assign INST_RDATA = inst_rdata_q;
  assign DATA_RDATA = data_rdata_q;
  assign STALL_REQ  = (state != IDLE) || (INST_CE && DATA_CE);

endmodule

// File: tb/tb_inst_sram_ctrl.sv
// Directed bench for inst_sram_ctrl: fetch, write, arbitration, reset abort.
// Honours SRAM_WAIT_STATE_EN by adding the extra read cycle.
module tb_inst_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_ce, inst_we;
  logic [3:0]  inst_be;
  logic [31:0] inst_wdata, inst_vaddr, inst_rdata;
  logic        data_ce, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata, data_vaddr, data_rdata;
  logic        stall;
  logic [19:0] ram_addr;
  logic [3:0]  ram_be_n;
  logic        ram_ce_n, ram_oe_n, ram_we_n;
  logic [31:0] ram_dq_o, ram_dq_i;
  logic        ram_dq_oe;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  inst_sram_ctrl dut (
    .CLK(clk), .RST(rst),
    .INST_CE(inst_ce), .INST_WE(inst_we),
    .INST_BE(inst_be), .INST_WDATA(inst_wdata),
    .INST_VADDR(inst_vaddr), .INST_RDATA(inst_rdata),
    .DATA_CE(data_ce), .DATA_WE(data_we),
    .DATA_BE(data_be), .DATA_WDATA(data_wdata),
    .DATA_VADDR(data_vaddr), .DATA_RDATA(data_rdata),
    .STALL_REQ(stall),
    .RAM_ADDR(ram_addr), .RAM_BE_N(ram_be_n),
    .RAM_CE_N(ram_ce_n), .RAM_OE_N(ram_oe_n),
    .RAM_WE_N(ram_we_n), .RAM_DQ_O(ram_dq_o),
    .RAM_DQ_OE(ram_dq_oe), .RAM_DQ_I(ram_dq_i)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Extra read cycle when the wait state is compiled in.
  task automatic rd_hold(input string tag);
`ifdef SRAM_WAIT_STATE_EN
    tick();
    #1;
    chk({tag, "_wait_oe"}, 32'(ram_oe_n), 0);
    chk({tag, "_wait_stall"}, 32'(stall), 1);
`else
    chk({tag, "_nowait_stall"}, 32'(stall), 1);
`endif
  endtask

  initial begin
    rst = 1'b1;
    inst_ce = 0; inst_we = 0; inst_be = 0;
    inst_wdata = 0; inst_vaddr = 0;
    data_ce = 0; data_we = 0; data_be = 0;
    data_wdata = 0; data_vaddr = 0;
    ram_dq_i = 0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_ce_n", 32'(ram_ce_n), 1);
    chk("rst_oe_n", 32'(ram_oe_n), 1);
    chk("rst_we_n", 32'(ram_we_n), 1);
    chk("rst_be_n", 32'(ram_be_n), 32'hF);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_dq_o", ram_dq_o, 0);
    chk("rst_dq_oe", 32'(ram_dq_oe), 0);
    chk("rst_irdata", inst_rdata, 0);
    chk("rst_drdata", data_rdata, 0);
    chk("rst_stall", 32'(stall), 0);

    // reset beats a pending request
    rst = 1'b1;
    inst_ce = 1;
    tick();
    chk("rstprio_ce_n", 32'(ram_ce_n), 1);
    rst = 1'b0;
    inst_ce = 0;
    #1;
    chk("rstprio_stall", 32'(stall), 0);

    // instruction fetch from reset vector
    inst_vaddr = 32'hBFC00000;
    inst_ce = 1;
    ram_dq_i = 32'h11112222;
    #1;
    chk("t1_n_stall", 32'(stall), 0);
    tick();
    inst_ce = 0;
    #1;
    chk("t1_ce_n", 32'(ram_ce_n), 0);
    chk("t1_oe_n", 32'(ram_oe_n), 0);
    chk("t1_we_n", 32'(ram_we_n), 1);
    chk("t1_be_n", 32'(ram_be_n), 0);
    chk("t1_dq_oe", 32'(ram_dq_oe), 0);
    chk("t1_addr", 32'(ram_addr), 0);
    chk("t1_stall", 32'(stall), 1);
    rd_hold("t1");
    tick();
    #1;
    chk("t1_irdata", inst_rdata, 32'h11112222);
    chk("t1_drdata", data_rdata, 0);
    chk("t1_idle_ce", 32'(ram_ce_n), 1);
    chk("t1_idle_st", 32'(stall), 0);

    // partial-byte write; inputs scrambled after launch
    data_ce = 1; data_we = 1;
    data_vaddr = 32'h80000010;
    data_be = 4'b0011;
    data_wdata = 32'h12345678;
    #1;
    chk("t2_n_stall", 32'(stall), 0);
    tick();
    data_ce = 0; data_we = 0;
    data_wdata = 32'hFFFFFFFF;
    data_vaddr = 0;
    data_be = 4'hF;
    #1;
    chk("t2s_ce_n", 32'(ram_ce_n), 0);
    chk("t2s_addr", 32'(ram_addr), 32'h4);
    chk("t2s_be_n", 32'(ram_be_n), 32'hC);
    chk("t2s_we_n", 32'(ram_we_n), 1);
    chk("t2s_oe_n", 32'(ram_oe_n), 1);
    chk("t2s_dq_oe", 32'(ram_dq_oe), 1);
    chk("t2s_dq_o", ram_dq_o, 32'h12345678);
    chk("t2s_stall", 32'(stall), 1);
    tick();
    #1;
    chk("t2p_we_n", 32'(ram_we_n), 0);
    chk("t2p_oe_n", 32'(ram_oe_n), 1);
    chk("t2p_addr", 32'(ram_addr), 32'h4);
    chk("t2p_be_n", 32'(ram_be_n), 32'hC);
    chk("t2p_dq_o", ram_dq_o, 32'h12345678);
    chk("t2p_dq_oe", 32'(ram_dq_oe), 1);
    tick();
    #1;
    chk("t2d_we_n", 32'(ram_we_n), 1);
    chk("t2d_dq_oe", 32'(ram_dq_oe), 1);
    chk("t2d_be_n", 32'(ram_be_n), 32'hC);
    chk("t2d_dq_o", ram_dq_o, 32'h12345678);
    tick();
    #1;
    chk("t2i_dq_oe", 32'(ram_dq_oe), 0);
    chk("t2i_ce_n", 32'(ram_ce_n), 1);
    chk("t2i_irdata", inst_rdata, 32'h11112222);
    chk("t2i_drdata", data_rdata, 0);

    // simultaneous requests: data first, fetch after
    inst_vaddr = 32'hBFC00004;
    inst_ce = 1;
    data_ce = 1; data_we = 0;
    data_vaddr = 32'h80000100;
    ram_dq_i = 32'hAAAA5555;
    #1;
    chk("t3_n_stall", 32'(stall), 1);
    tick();
    data_ce = 0;
    #1;
    chk("t3d_addr", 32'(ram_addr), 32'h40);
    chk("t3d_oe_n", 32'(ram_oe_n), 0);
    chk("t3d_stall", 32'(stall), 1);
    rd_hold("t3d");
    tick();
    ram_dq_i = 32'h33334444;
    #1;
    chk("t3_drdata", data_rdata, 32'hAAAA5555);
    chk("t3_irdata_keep", inst_rdata, 32'h11112222);
    tick();
    inst_ce = 0;
    #1;
    chk("t3i_addr", 32'(ram_addr), 32'h1);
    chk("t3i_oe_n", 32'(ram_oe_n), 0);
    chk("t3i_stall", 32'(stall), 1);
    rd_hold("t3i");
    tick();
    #1;
    chk("t3_irdata", inst_rdata, 32'h33334444);
    chk("t3_drdata2", data_rdata, 32'hAAAA5555);

    // all-zero byte enables still run full write
    data_ce = 1; data_we = 1;
    data_vaddr = 32'h80000020;
    data_be = 4'h0;
    data_wdata = 32'h0BADF00D;
    tick();
    data_ce = 0; data_we = 0;
    #1;
    chk("t4s_be_n", 32'(ram_be_n), 32'hF);
    chk("t4s_dq_oe", 32'(ram_dq_oe), 1);
    chk("t4s_addr", 32'(ram_addr), 32'h8);
    tick();
    #1;
    chk("t4p_we_n", 32'(ram_we_n), 0);
    chk("t4p_be_n", 32'(ram_be_n), 32'hF);
    tick();
    #1;
    chk("t4d_we_n", 32'(ram_we_n), 1);
    chk("t4d_dq_oe", 32'(ram_dq_oe), 1);
    tick();
    #1;
    chk("t4i_dq_oe", 32'(ram_dq_oe), 0);

    // reset during write pulse
    data_ce = 1; data_we = 1;
    data_vaddr = 32'h80000030;
    data_be = 4'hF;
    data_wdata = 32'h55AA55AA;
    tick();
    data_ce = 0; data_we = 0;
    tick();
    #1;
    chk("t5p_we_n", 32'(ram_we_n), 0);
    rst = 1'b1;
    tick();
    #1;
    chk("t5r_we_n", 32'(ram_we_n), 1);
    chk("t5r_dq_oe", 32'(ram_dq_oe), 0);
    chk("t5r_ce_n", 32'(ram_ce_n), 1);
    chk("t5r_addr", 32'(ram_addr), 0);
    chk("t5r_irdata", inst_rdata, 0);
    chk("t5r_drdata", data_rdata, 0);
    rst = 1'b0;

    // fetch then data read
    inst_vaddr = 32'hBFC00008;
    inst_ce = 1;
    ram_dq_i = 32'hCAFEF00D;
    tick();
    inst_ce = 0;
    #1;
    chk("t6i_addr", 32'(ram_addr), 32'h2);
    rd_hold("t6i");
    tick();
    #1;
    chk("t6_irdata", inst_rdata, 32'hCAFEF00D);
    data_ce = 1; data_we = 0;
    data_vaddr = 32'h80000200;
    ram_dq_i = 32'hDEADBEEF;
    tick();
    data_ce = 0;
    #1;
    chk("t6d_addr", 32'(ram_addr), 32'h80);
    chk("t6d_dq_oe", 32'(ram_dq_oe), 0);
    rd_hold("t6d");
    tick();
    #1;
    chk("t6_drdata", data_rdata, 32'hDEADBEEF);
    chk("t6_irdata_keep", inst_rdata, 32'hCAFEF00D);

    // back-to-back fetches with request held
    inst_vaddr = 32'hBFC0000C;
    inst_ce = 1;
    ram_dq_i = 32'h01010101;
    tick();
    #1;
    chk("t7a_stall", 32'(stall), 1);
    rd_hold("t7a");
    tick();
    ram_dq_i = 32'h02020202;
    #1;
    chk("t7a_irdata", inst_rdata, 32'h01010101);
    chk("t7a_idle_st", 32'(stall), 0);
    tick();
    inst_ce = 0;
    #1;
    chk("t7b_stall", 32'(stall), 1);
    rd_hold("t7b");
    tick();
    #1;
    chk("t7b_irdata", inst_rdata, 32'h02020202);
    chk("t7b_drdata", data_rdata, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
